game_status: RTL and testbench
==============================

GAME_STATUS -- requirements
Module: game_status

Interface
REQ-001 Parameter CLK_HZ, default 25000000, clk frequency used to derive the 1 s tick.
REQ-002 Parameter LIVES_INIT, default 3, player lives at game start (range 1..3).
REQ-003 Parameter KILL_TARGET, default 20, classic-mode kills needed to win (range 1..255).
REQ-004 Parameter TIME_LIMIT, default 99, classic-mode countdown in seconds (range 1..127).
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 enable_game_classic  in  1  level, classic game running.
REQ-008 enable_game_infinity  in  1  level, infinity game running.
REQ-009 mytank_hit  in  1  one-cycle pulse, player tank destroyed.
REQ-010 enytank_kill  in  4  one-cycle pulse per enemy tank 1..4 destroyed.
REQ-011 gameover_classic  out  1  registered level, classic game ended.
REQ-012 gameover_infinity  out  1  registered level, infinity game ended.
REQ-013 win  out  1  classic game ended by reaching KILL_TARGET.
REQ-014 lives  out  2  remaining lives.
REQ-015 kills  out  8  kills this game, saturating at 255.
REQ-016 score  out  14  score this game, saturating at 9999.
REQ-017 time_left  out  7  classic countdown seconds.

Function
REQ-018 FSM states: IDLE, RUN_C, RUN_I, OVER.
REQ-019 IDLE->RUN_C when enable_game_classic=1; IDLE->RUN_I when only enable_game_infinity=1; if both are high, classic takes priority.
REQ-020 On the IDLE->RUN transition: lives<=LIVES_INIT, kills<=0, score<=0, time_left<=TIME_LIMIT, win<=0, tick counter<=0.
REQ-021 In RUN_x, mytank_hit with lives>0 decrements lives by exactly 1, irrespective of other events that cycle.
REQ-022 In RUN_x, kills increases by popcount(enytank_kill) (0..4) and score by 10 per kill, each saturating.
REQ-023 RUN_C->OVER, gameover_classic<=1, on the cycle after lives reach 0, time_left reaches 0, or kills>=KILL_TARGET; win<=1 only if lives>0.
REQ-024 RUN_I->OVER, gameover_infinity<=1, on the cycle after lives reach 0; no kill or time limit applies.
REQ-025 A hit and a target-reaching kill in the same cycle with lives=1: the loss wins, so win=0.
REQ-026 RUN_x->IDLE without setting gameover if the corresponding enable drops (abort); counters hold.
REQ-027 In OVER, inputs are ignored and counters hold for display; OVER->IDLE when both enables are 0, and gameover_* clears on that transition.
REQ-028 Tick: a counter 0..CLK_HZ-1 runs only in RUN_C; at wrap, time_left decrements by 1, stopping at 0.
REQ-029 gameover_* never asserts in IDLE, so a new game cannot end on its first cycle.

Reset
REQ-030 rst=1: state IDLE, gameover_classic=0, gameover_infinity=0, win=0, lives=LIVES_INIT, kills=0, score=0, time_left=TIME_LIMIT, tick counter=0.
REQ-031 rst mid-game overrides all events that cycle; normal operation resumes the cycle after rst falls.

Configuration
REQ-032 Macro GAME_STATUS_TIMER_EN defined: tick counter and countdown per REQ-028, with time-expiry ending the classic game.
REQ-033 Macro undefined: no tick counter, time_left tied to 0, classic game ends only on lives or kills.

Structure
REQ-034 Shared package game_pkg holds the FSM state encoding, the LIVES_W/KILLS_W/SCORE_W/TIME_W widths, SCORE_MAX=9999 and SCORE_PER_KILL=10.
REQ-035 One sub-module, game_sec_tick, is the parameterised 1 s pulse generator with an enable input; it is instantiated only under GAME_STATUS_TIMER_EN.

Verification (bench CLK_HZ=10, LIVES_INIT=3, KILL_TARGET=4, TIME_LIMIT=5, macro defined)
REQ-036 Classic start, 3 hits spaced 3 cycles apart -> lives 3,2,1,0; gameover_classic=1 one cycle after lives=0; win=0.
REQ-037 Classic, enytank_kill=4'b1111 in one cycle -> kills=4, score=40, then gameover_classic=1, win=1.
REQ-038 Classic, idle for 50 cycles -> time_left steps 5..0 every 10 cycles; gameover at 0; with the macro undefined, no gameover and time_left=0.
REQ-039 Infinity, 300 kills -> kills saturates at 255, score at 2550, no gameover; 3 hits -> gameover_infinity=1.
REQ-040 In OVER, drop both enables -> IDLE next cycle, gameover cleared; re-enabling classic -> counters reload, no gameover for at least 1 cycle.
REQ-041 Assert rst mid-RUN_C with a simultaneous hit -> every output equals its reset value, lives=3.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared FSM encoding, counter widths and scoring constants for game_status.
package game_pkg;
    typedef enum logic [1:0] {IDLE, RUN_C, RUN_I, OVER} state_t;
    localparam int LIVES_W        = 2;
    localparam int KILLS_W        = 8;
    localparam int SCORE_W        = 14;
    localparam int TIME_W         = 7;
    localparam int SCORE_MAX      = 9999;
    localparam int SCORE_PER_KILL = 10;
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction
endpackage

// File: rtl/game_sec_tick.sv
// game_sec_tick: one-cycle pulse every CLK_HZ enabled cycles; counter clears on i_clr.
// Only built when GAME_STATUS_TIMER_EN is defined, the sole configuration that uses it.
`ifdef GAME_STATUS_TIMER_EN
module game_sec_tick #(
    parameter int CLK_HZ = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int CW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    logic [CW-1:0] r_cnt;
    assign o_tick = i_en && r_cnt == CW'(CLK_HZ - 1);
    always_ff @(posedge clk) begin
        if (rst || i_clr) r_cnt <= '0;
        else if (i_en)    r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
endmodule
`endif

// File: rtl/game_status.sv
// game_status: lives/kills/score/countdown tracking and game-over FSM for classic and infinity modes.
// Optional macro GAME_STATUS_TIMER_EN enables the 1 s countdown and classic time-expiry.
module game_status import game_pkg::*; #(
    parameter int CLK_HZ      = 25000000,
    parameter int LIVES_INIT  = 3,
    parameter int KILL_TARGET = 20,
    parameter int TIME_LIMIT  = 99
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_game_classic,
    input  logic               enable_game_infinity,
    input  logic               mytank_hit,
    input  logic [3:0]         enytank_kill,
    output logic               gameover_classic,
    output logic               gameover_infinity,
    output logic               win,
    output logic [LIVES_W-1:0] lives,
    output logic [KILLS_W-1:0] kills,
    output logic [SCORE_W-1:0] score,
    output logic [TIME_W-1:0]  time_left
);
`ifdef GAME_STATUS_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
    localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(TIME_LIMIT);
`else
    localparam bit TIMER_ON = 1'b0;
    localparam logic [TIME_W-1:0] TIME_INIT = '0;
`endif
    state_t               r_state, w_state;
    logic                 r_go_c, w_go_c, r_go_i, w_go_i, r_win, w_win;
    logic [LIVES_W-1:0]   r_lives, w_lives;
    logic [KILLS_W-1:0]   r_kills, w_kills;
    logic [SCORE_W-1:0]   r_score, w_score;
    logic [TIME_W-1:0]    r_time, w_time;
    logic                 w_start, w_tick, w_end, w_run_en, w_target;
    logic [KILLS_W:0]     w_kill_sum;
    logic [KILLS_W-1:0]   w_kills_sat;
    logic [SCORE_W:0]     w_score_sum;
    logic [SCORE_W-1:0]   w_score_sat;
    assign w_start = r_state == IDLE && (enable_game_classic || enable_game_infinity);
`ifdef GAME_STATUS_TIMER_EN
    game_sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start),
        .i_en   (r_state == RUN_C),
        .o_tick (w_tick)
    );
`else
    assign w_tick = 1'b0;
`endif
    // Score follows the kills actually counted, so it stops when kills saturate.
    assign w_kill_sum  = {1'b0, r_kills} + (KILLS_W + 1)'(popcount4(enytank_kill));
    assign w_kills_sat = w_kill_sum[KILLS_W] ? '1 : w_kill_sum[KILLS_W-1:0];
    assign w_score_sum = {1'b0, r_score} + (SCORE_W + 1)'(w_kills_sat - r_kills) * (SCORE_W + 1)'(SCORE_PER_KILL);
    assign w_score_sat = w_score_sum > (SCORE_W + 1)'(SCORE_MAX) ? SCORE_W'(SCORE_MAX) : w_score_sum[SCORE_W-1:0];
    assign w_target    = r_kills >= KILLS_W'(KILL_TARGET);
    assign w_run_en    = r_state == RUN_C ? enable_game_classic : enable_game_infinity;
    // End conditions use registered values, so the game ends the cycle after they occur.
    assign w_end       = r_lives == '0 || (r_state == RUN_C && (w_target || (TIMER_ON && r_time == '0)));
    always_comb begin
        w_state = r_state;
        w_go_c  = r_go_c;
        w_go_i  = r_go_i;
        w_win   = r_win;
        w_lives = r_lives;
        w_kills = r_kills;
        w_score = r_score;
        w_time  = r_time;
        case (r_state)
            IDLE: if (w_start) begin
                w_state = enable_game_classic ? RUN_C : RUN_I;
                w_lives = LIVES_W'(LIVES_INIT);
                w_kills = '0;
                w_score = '0;
                w_time  = TIME_INIT;
                w_win   = 1'b0;
            end
            RUN_C, RUN_I: if (!w_run_en) begin
                w_state = IDLE;
            end else if (w_end) begin
                w_state = OVER;
                w_go_c  = r_state == RUN_C;
                w_go_i  = r_state == RUN_I;
                w_win   = r_state == RUN_C && r_lives != '0 && w_target;
            end else begin
                w_lives = mytank_hit && r_lives != '0 ? r_lives - 1'b1 : r_lives;
                w_kills = w_kills_sat;
                w_score = w_score_sat;
                w_time  = r_state == RUN_C && w_tick && r_time != '0 ? r_time - 1'b1 : r_time;
            end
            OVER: if (!enable_game_classic && !enable_game_infinity) begin
                w_state = IDLE;
                w_go_c  = 1'b0;
                w_go_i  = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_go_c  <= 1'b0;
            r_go_i  <= 1'b0;
            r_win   <= 1'b0;
            r_lives <= LIVES_W'(LIVES_INIT);
            r_kills <= '0;
            r_score <= '0;
            r_time  <= TIME_INIT;
        end else begin
            r_state <= w_state;
            r_go_c  <= w_go_c;
            r_go_i  <= w_go_i;
            r_win   <= w_win;
            r_lives <= w_lives;
            r_kills <= w_kills;
            r_score <= w_score;
            r_time  <= w_time;
        end
    end
    assign gameover_classic  = r_go_c;
    assign gameover_infinity = r_go_i;
    assign win               = r_win;
    assign lives             = r_lives;
    assign kills             = r_kills;
    assign score             = r_score;
    assign time_left         = r_time;
endmodule

// File: tb/tb_game_status.sv
// tb_game_status: directed checks of game_status with CLK_HZ=10, LIVES_INIT=3, KILL_TARGET=4, TIME_LIMIT=5.
// Countdown expectations follow GAME_STATUS_TIMER_EN as seen by this compilation.
module tb_game_status;
`ifdef GAME_STATUS_TIMER_EN
    localparam int TL = 5;
`else
    localparam int TL = 0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_c = 1'b0, en_i = 1'b0, hit = 1'b0;
    logic [3:0]  kill = 4'b0;
    logic        go_c, go_i, win;
    logic [1:0]  lives;
    logic [7:0]  kills;
    logic [13:0] score;
    logic [6:0]  time_left;
    int          checks = 0;
    int          errors = 0;

    game_status #(.CLK_HZ(10), .LIVES_INIT(3), .KILL_TARGET(4), .TIME_LIMIT(5)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable_game_classic  (en_c),
        .enable_game_infinity (en_i),
        .mytank_hit           (hit),
        .enytank_kill         (kill),
        .gameover_classic     (go_c),
        .gameover_infinity    (go_i),
        .win                  (win),
        .lives                (lives),
        .kills                (kills),
        .score                (score),
        .time_left            (time_left)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_lives"}, 32'(lives), 3);
        chk({tag, "_kills"}, 32'(kills), 0);
        chk({tag, "_score"}, 32'(score), 0);
        chk({tag, "_time"}, 32'(time_left), TL);
        chk({tag, "_go_c"}, 32'(go_c), 0);
        chk({tag, "_go_i"}, 32'(go_i), 0);
        chk({tag, "_win"}, 32'(win), 0);
    endtask

    initial begin
        step(2);
        chk_reset("reset");
        rst = 1'b0;
        // Classic: three hits three cycles apart
        en_c = 1'b1; step(1);
        chk("c_start_lives", 32'(lives), 3);
        hit = 1'b1; step(1); hit = 1'b0;
        chk("hit1_lives", 32'(lives), 2);
        step(2);
        hit = 1'b1; step(1); hit = 1'b0;
        chk("hit2_lives", 32'(lives), 1);
        step(2);
        hit = 1'b1; step(1); hit = 1'b0;
        chk("hit3_lives", 32'(lives), 0);
        chk("hit3_go_early", 32'(go_c), 0);
        step(1);
        chk("hit3_go_c", 32'(go_c), 1);
        chk("hit3_win", 32'(win), 0);
        chk("hit3_time", 32'(time_left), TL);
        // Leave OVER, then restart with reloaded counters
        en_c = 1'b0; step(1);
        chk("over_idle_go_c", 32'(go_c), 0);
        en_c = 1'b1; step(1);
        chk("restart_lives", 32'(lives), 3);
        chk("restart_go_c", 32'(go_c), 0);
        chk("restart_time", 32'(time_left), TL);
        // Four kills in one cycle reach the target
        kill = 4'b1111; step(1); kill = 4'b0;
        chk("kill4_kills", 32'(kills), 4);
        chk("kill4_score", 32'(score), 40);
        chk("kill4_go_early", 32'(go_c), 0);
        step(1);
        chk("kill4_go_c", 32'(go_c), 1);
        chk("kill4_win", 32'(win), 1);
        hit = 1'b1; kill = 4'b0011; step(1); hit = 1'b0; kill = 4'b0;
        chk("over_hold_lives", 32'(lives), 3);
        chk("over_hold_kills", 32'(kills), 4);
        en_c = 1'b0; step(1);
        chk("kill4_idle_go_c", 32'(go_c), 0);
        chk("kill4_idle_win", 32'(win), 1);
        // Countdown
        en_c = 1'b1; step(1);
`ifdef GAME_STATUS_TIMER_EN
        step(9);
        chk("time_pre_tick", 32'(time_left), 5);
        step(1);
        chk("time_first_tick", 32'(time_left), 4);
        step(40);
        chk("time_zero", 32'(time_left), 0);
        chk("time_go_early", 32'(go_c), 0);
        step(1);
        chk("time_go_c", 32'(go_c), 1);
        chk("time_win", 32'(win), 0);
`else
        step(50);
        chk("notimer_time", 32'(time_left), 0);
        chk("notimer_go_c", 32'(go_c), 0);
`endif
        en_c = 1'b0; step(1);
        chk("time_idle_go_c", 32'(go_c), 0);
        // Infinity: 300 kills saturate, then three hits end it
        en_i = 1'b1; step(1);
        kill = 4'b1111; step(75); kill = 4'b0;
        chk("inf_kills", 32'(kills), 255);
        chk("inf_score", 32'(score), 2550);
        chk("inf_go_i_early", 32'(go_i), 0);
        chk("inf_time", 32'(time_left), TL);
        hit = 1'b1; step(3); hit = 1'b0;
        chk("inf_lives", 32'(lives), 0);
        chk("inf_go_i_pre", 32'(go_i), 0);
        step(1);
        chk("inf_go_i", 32'(go_i), 1);
        chk("inf_go_c", 32'(go_c), 0);
        en_i = 1'b0; step(1);
        chk("inf_idle_go_i", 32'(go_i), 0);
        // Reset mid-game with a simultaneous hit
        en_c = 1'b1; step(1);
        kill = 4'b0001; step(1); kill = 4'b0;
        chk("pre_rst_kills", 32'(kills), 1);
        step(2);
        rst = 1'b1; hit = 1'b1; step(1); rst = 1'b0; hit = 1'b0;
        chk_reset("midrst");
        step(1);
        chk("post_rst_lives", 32'(lives), 3);
        chk("post_rst_go_c", 32'(go_c), 0);
        // Hit and target-reaching kill together with one life left: loss
        kill = 4'b0111; step(1); kill = 4'b0;
        chk("tie_kills3", 32'(kills), 3);
        hit = 1'b1; step(2); hit = 1'b0;
        chk("tie_lives1", 32'(lives), 1);
        hit = 1'b1; kill = 4'b1000; step(1); hit = 1'b0; kill = 4'b0;
        chk("tie_lives0", 32'(lives), 0);
        chk("tie_kills4", 32'(kills), 4);
        step(1);
        chk("tie_go_c", 32'(go_c), 1);
        chk("tie_win", 32'(win), 0);
        en_c = 1'b0; step(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
